// File: rtl/ss_a2d_pkg.sv
// ss_a2d_pkg: state encoding and synchroniser timing constants
// shared by the single-slope A2D controller and its helpers.
package ss_a2d_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CNV,
    ACCUM,
    DONE
  } a2d_state_t;

  localparam int SYNC_LAT   = 2;
  localparam int SETTLE_LEN = SYNC_LAT + 1;

endpackage

// File: rtl/ss_a2d_mc_ctrl_gt_sync.sv
// gt_sync: two-flop comparator synchroniser plus a matching
// dac delay line so dac_d2 is the code that produced gt2.
module gt_sync #(
  parameter int DAC_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gt,
  input  logic [DAC_W-1:0] dac,
  output logic             gt2,
  output logic [DAC_W-1:0] dac_d2
);

  logic             gt1;
  logic [DAC_W-1:0] dac_d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt1    <= 1'b0;
      gt2    <= 1'b0;
      dac_d1 <= '0;
      dac_d2 <= '0;
    end else begin
      gt1    <= gt;
      gt2    <= gt1;
      dac_d1 <= dac;
      dac_d2 <= dac_d1;
    end
  end

endmodule

// File: rtl/ss_a2d_mc_ctrl.sv
// ss_a2d_mc_ctrl: multi-channel single-slope A2D controller with averaging.
// Define SS_A2D_SCAN_EN to scan all channels on each strt_cnv.
module ss_a2d_mc_ctrl
  import ss_a2d_pkg::*;
#(
  parameter int DAC_W    = 10,
  parameter int SMP_LOG2 = 3,
  parameter int NUM_CH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      strt_cnv,
  input  logic [$clog2(NUM_CH)-1:0] chnl,
  input  logic                      gt,
  output logic [DAC_W-1:0]          dac,
  output logic [$clog2(NUM_CH)-1:0] ch_sel,
  output logic                      busy,
  output logic [DAC_W-1:0]          result,
  output logic [$clog2(NUM_CH)-1:0] rslt_ch,
  output logic                      ovr,
  output logic                      cnv_cmplt,
  output logic                      scan_done
);

  localparam int CW  = $clog2(NUM_CH);
  localparam int AW  = DAC_W + SMP_LOG2;
  localparam int SCW = $clog2(SETTLE_LEN);

  localparam logic [SCW-1:0]      SET_LAST = SCW'(SETTLE_LEN - 1);
  localparam logic [SMP_LOG2-1:0] SMP_LAST = '1;
  localparam logic [DAC_W-1:0]    DAC_MAX  = '1;
  localparam logic [CW-1:0]       CH_LAST  = CW'(NUM_CH - 1);

`ifdef SS_A2D_SCAN_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif

  a2d_state_t state, state_nxt;

  logic                gt2;
  logic [DAC_W-1:0]    dac_d2;
  logic [SCW-1:0]      set_cnt;
  logic [SMP_LOG2-1:0] smp_cnt;
  logic [AW-1:0]       acc;
  logic [DAC_W-1:0]    sample;
  logic                ovr_flg;
  logic                scan_more;

  gt_sync #(
    .DAC_W (DAC_W)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .gt     (gt),
    .dac    (dac),
    .gt2    (gt2),
    .dac_d2 (dac_d2)
  );

  assign scan_more = SCAN_EN && (ch_sel != CH_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (strt_cnv) state_nxt = SETTLE;
      SETTLE: if (set_cnt == SET_LAST) state_nxt = CNV;
      CNV:    if (gt2 || dac_d2 == DAC_MAX) state_nxt = ACCUM;
      ACCUM:  state_nxt = (smp_cnt == SMP_LAST) ? DONE : SETTLE;
      DONE:   state_nxt = scan_more ? SETTLE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac       <= '0;
      ch_sel    <= '0;
      busy      <= 1'b0;
      result    <= '0;
      rslt_ch   <= '0;
      ovr       <= 1'b0;
      cnv_cmplt <= 1'b0;
      scan_done <= 1'b0;
      set_cnt   <= '0;
      smp_cnt   <= '0;
      acc       <= '0;
      sample    <= '0;
      ovr_flg   <= 1'b0;
    end else begin
      cnv_cmplt <= 1'b0;
      scan_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (strt_cnv) begin
            ch_sel  <= SCAN_EN ? '0 : chnl;
            dac     <= '0;
            set_cnt <= '0;
            smp_cnt <= '0;
            acc     <= '0;
            ovr_flg <= 1'b0;
            busy    <= 1'b1;
          end
        end
        SETTLE: set_cnt <= set_cnt + SCW'(1);
        CNV: begin
          // gt2 wins over saturation so a full-scale input is not over-range
          if (gt2) begin
            sample <= dac_d2;
          end else if (dac_d2 == DAC_MAX) begin
            sample  <= DAC_MAX;
            ovr_flg <= 1'b1;
          end else if (dac != DAC_MAX) begin
            dac <= dac + DAC_W'(1);
          end
        end
        ACCUM: begin
          acc <= acc + AW'(sample);
          if (smp_cnt != SMP_LAST) begin
            smp_cnt <= smp_cnt + SMP_LOG2'(1);
            dac     <= '0;
            set_cnt <= '0;
          end
        end
        DONE: begin
          result    <= acc[AW-1:SMP_LOG2];
          rslt_ch   <= ch_sel;
          ovr       <= ovr_flg;
          cnv_cmplt <= 1'b1;
          scan_done <= SCAN_EN && !scan_more;
          busy      <= scan_more;
          dac       <= '0;
          if (scan_more) begin
            ch_sel  <= ch_sel + CW'(1);
            set_cnt <= '0;
            smp_cnt <= '0;
            acc     <= '0;
            ovr_flg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ss_a2d_mc_ctrl.sv
// tb_ss_a2d_mc_ctrl: comparator model plus averaging reference
// for the single-slope A2D controller.
`timescale 1ns/1ps
module tb_ss_a2d_mc_ctrl;

  localparam int DAC_W    = 10;
  localparam int SMP_LOG2 = 3;
  localparam int NUM_CH   = 4;
  localparam int CW       = 2;
  localparam int NS       = 8;
  localparam int VMAX     = 1023;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b1;
  logic              strt_cnv = 1'b0;
  logic [CW-1:0]     chnl     = '0;
  logic              gt;
  logic [DAC_W-1:0]  dac;
  logic [CW-1:0]     ch_sel;
  logic              busy;
  logic [DAC_W-1:0]  result;
  logic [CW-1:0]     rslt_ch;
  logic              ovr;
  logic              cnv_cmplt;
  logic              scan_done;

  ss_a2d_mc_ctrl #(
    .DAC_W    (DAC_W),
    .SMP_LOG2 (SMP_LOG2),
    .NUM_CH   (NUM_CH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .strt_cnv  (strt_cnv),
    .chnl      (chnl),
    .gt        (gt),
    .dac       (dac),
    .ch_sel    (ch_sel),
    .busy      (busy),
    .result    (result),
    .rslt_ch   (rslt_ch),
    .ovr       (ovr),
    .cnv_cmplt (cnv_cmplt),
    .scan_done (scan_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    int ch;
    bit ovr;
    bit sd;
    int lat;
    int bound;
    bit first;
    int start;
  } exp_t;

  exp_t exp_a[64];
  int   vin_tab[NUM_CH][NS];
  int   idx = 0;
  int   base = 0;
  int   cyc = 0;
  int   n_push = 0;
  int   n_pop = 0;
  int   checks = 0;
  int   failures = 0;
  int   last_res = 0;
  int   last_ch = 0;
  bit   last_ovr = 1'b0;
  bit   prev_cmplt = 1'b0;
  int   last_cyc = 0;
  logic [DAC_W-1:0] prev_dac = '0;

  // comparator: gt = (dac >= vin) for the sample currently in flight
  assign gt = int'(dac) >= vin_tab[ch_sel][(idx - base) % NS];

  always @(posedge clk) cyc++;

  // a new sample starts whenever the ramp drops back to zero
  always @(negedge clk) begin
    if (prev_dac != '0 && dac == '0) idx++;
    prev_dac = dac;
  end

  function automatic exp_t model(input int ch, input int fres, input bit fovr);
    exp_t e;
    int   sum, s, lat;
    bit   ov, lat_ok;
    sum = 0; lat = 1; ov = 1'b0; lat_ok = 1'b1;
    for (int i = 0; i < NS; i++) begin
      s = vin_tab[ch][i];
      if (s > VMAX) begin
        s  = VMAX;
        ov = 1'b1;
      end
      if (s < 1) lat_ok = 1'b0;
      sum += s;
      lat += 7 + s;
    end
    e.res   = (fres >= 0) ? fres : (sum >> SMP_LOG2);
    e.ovr   = (fres >= 0) ? fovr : ov;
    e.ch    = ch;
    e.sd    = 1'b0;
    e.lat   = lat_ok ? lat : -1;
    e.bound = lat + 16;
    e.first = 1'b1;
    e.start = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   pend, ref_c;
    if (!rst_n) begin
      chk("reset_outputs",
          int'({dac, ch_sel, busy, result, rslt_ch, ovr, cnv_cmplt, scan_done}), 0);
      last_res   = 0;
      last_ch    = 0;
      last_ovr   = 1'b0;
      prev_cmplt = 1'b0;
      n_pop      = n_push;
    end else begin
      pend = n_push - n_pop;
      if (cnv_cmplt) begin
        if (pend == 0) begin
          chk("unexpected_cmplt", 1, 0);
        end else begin
          e = exp_a[n_pop % 64];
          n_pop++;
          chk("result", int'(result), e.res);
          chk("rslt_ch", int'(rslt_ch), e.ch);
          chk("ovr", int'(ovr), int'(e.ovr));
          chk("scan_done", int'(scan_done), int'(e.sd));
          chk("busy_at_cmplt", int'(busy), (n_push - n_pop > 0) ? 1 : 0);
          chk("cmplt_width", int'(prev_cmplt), 0);
          if (e.lat >= 0)
            chk("latency", cyc - (e.first ? e.start : last_cyc), e.lat);
          last_res = e.res;
          last_ch  = e.ch;
          last_ovr = e.ovr;
        end
        last_cyc = cyc;
      end else begin
        chk("held_result", int'(result), last_res);
        chk("held_rslt_ch", int'(rslt_ch), last_ch);
        chk("held_ovr", int'(ovr), int'(last_ovr));
        chk("scan_done_idle", int'(scan_done), 0);
        chk("busy", int'(busy), (pend > 0) ? 1 : 0);
        if (pend > 0) begin
          e = exp_a[n_pop % 64];
          ref_c = e.first ? e.start : last_cyc;
          if (cyc - ref_c > e.bound) begin
            chk("timeout", cyc - ref_c, e.bound);
            n_pop++;
          end
        end
      end
      prev_cmplt = cnv_cmplt;
    end
  end

  task automatic fill(input int ch, input int v);
    for (int i = 0; i < NS; i++) vin_tab[ch][i] = v;
  endtask

  task automatic push(input int ch, input int fres, input bit fovr,
                      input bit first, input bit sd);
    exp_t e;
    e       = model(ch, fres, fovr);
    e.first = first;
    e.sd    = sd;
    e.start = cyc;
    exp_a[n_push % 64] = e;
    n_push++;
  endtask

  task automatic start(input int ch, input int fres, input bit fovr);
    @(posedge clk); #1;
    strt_cnv = 1'b1;
    chnl     = CW'(ch);
    @(posedge clk); #1;
    strt_cnv = 1'b0;
    base     = idx;
    push(ch, fres, fovr, 1'b1, 1'b0);
  endtask

  task automatic wait_idle();
    wait (n_pop == n_push);
    @(posedge clk); #1;
  endtask

  task automatic conv(input int ch, input bit mid, input int fres, input bit fovr);
    start(ch, fres, fovr);
    if (mid) begin
      repeat (40) @(posedge clk);
      #1;
      strt_cnv = 1'b1;
      chnl     = CW'(ch + 1);
      @(posedge clk); #1;
      strt_cnv = 1'b0;
    end
    wait_idle();
  endtask

`ifndef SS_A2D_SCAN_EN
  // second start is held high through DONE; only the IDLE cycle may accept it
  task automatic conv_b2b(input int c1, input int c2);
    exp_t e;
    start(c1, -1, 1'b0);
    e = exp_a[(n_push - 1) % 64];
    for (int k = 0; k < e.bound && cyc < e.start + e.lat - 1; k++) begin
      @(posedge clk); #1;
    end
    strt_cnv = 1'b1;
    chnl     = CW'(c2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    strt_cnv = 1'b0;
    base     = idx;
    push(c2, -1, 1'b0, 1'b1, 1'b0);
    wait_idle();
  endtask
`else
  task automatic scan(input bit pin);
    @(posedge clk); #1;
    strt_cnv = 1'b1;
    chnl     = CW'($urandom_range(NUM_CH - 1, 0));
    @(posedge clk); #1;
    strt_cnv = 1'b0;
    base     = idx;
    for (int c = 0; c < NUM_CH; c++)
      push(c, pin ? 10 * (c + 1) : -1, 1'b0, c == 0, c == NUM_CH - 1);
    wait_idle();
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog: no finish after %0d cycles", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int c = 0; c < NUM_CH; c++) fill(c, 1);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

`ifdef SS_A2D_SCAN_EN
    for (int c = 0; c < NUM_CH; c++) fill(c, 10 * (c + 1));
    scan(1'b1);
    for (int t = 0; t < 2; t++) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int i = 0; i < NS; i++) vin_tab[c][i] = $urandom_range(120, 1);
      scan(1'b0);
    end
`else
    fill(2, 300);  conv(2, 1'b0, 300, 1'b0);
    fill(1, 0);    conv(1, 1'b0, 0, 1'b0);
    fill(3, 1023); conv(3, 1'b0, 1023, 1'b0);
    fill(0, 1024); conv(0, 1'b0, 1023, 1'b1);
    for (int i = 0; i < NS; i++) vin_tab[1][i] = 100 + i;
    conv(1, 1'b1, 103, 1'b0);

    // abort during the ramp of sample 4
    fill(2, 300);
    start(2, 300, 1'b0);
    for (int k = 0; k < 5000 && (idx - base) != 4; k++) @(posedge clk);
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fill(3, 50); conv(3, 1'b0, 50, 1'b0);

    fill(0, 77); fill(2, 5);
    conv_b2b(0, 2);

    for (int t = 0; t < 12; t++) begin
      int ch, mode;
      ch   = $urandom_range(NUM_CH - 1, 0);
      mode = $urandom_range(2, 0);
      if (mode == 0) fill(ch, $urandom_range(255, 0));
      else
        for (int i = 0; i < NS; i++)
          vin_tab[ch][i] = $urandom_range(mode == 1 ? 300 : 60, 1);
      if (mode == 2) vin_tab[ch][$urandom_range(NS - 1, 0)] = 1024 + $urandom_range(20, 0);
      conv(ch, 1'b0, -1, 1'b0);
    end
`endif

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
